// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART word scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} e_sched_state;

  localparam logic [3:0] HDR_MAGIC      = 4'hA;
  localparam int         BYTES_PER_WORD = 4;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_MAGIC, id};
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_grant, wrapping.
// Zero latency; no flow control of its own.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any
);

  localparam int W = $clog2(N);

  logic found;
  int   cand;

  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      if (!found && req[cand]) begin
        found  = 1'b1;
        gnt_id = W'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin word scheduler feeding a shared byte UART; accept 1 cycle after req_valid,
// optional header then 4 bytes LSB first; byte held while byte_ready is low.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter bit ID_HEADER = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  input  logic                       byte_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       word_done
);

  localparam int IDW = $clog2(NUM_REQ);

  e_sched_state       state_q, state_d;
  logic [1:0]         idx_q, idx_d, idx_n;
  logic [31:0]        word_q, word_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     arb_gnt;
  logic               arb_any;
  logic               hs;

  logic [NUM_REQ-1:0] req_ready_d;
  logic [IDW-1:0]     grant_d;
  logic               busy_d, word_done_d, byte_valid_d;
  logic [7:0]         byte_data_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .gnt_id     (arb_gnt),
    .any        (arb_any)
  );

  assign hs = byte_valid && byte_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    idx_n        = idx_q + 2'd1;
    word_d       = word_q;
    last_d       = last_q;
    req_ready_d  = '0;
    grant_d      = grant_id;
    busy_d       = busy;
    word_done_d  = 1'b0;
    byte_valid_d = byte_valid;
    byte_data_d  = byte_data;
    case (state_q)
      S_IDLE: begin
        if (en && arb_any) begin
          word_d               = req_data[32*int'(arb_gnt) +: 32];
          req_ready_d[arb_gnt] = 1'b1;
          grant_d              = arb_gnt;
          busy_d               = 1'b1;
          byte_valid_d         = 1'b1;
          idx_d                = 2'd0;
          // Outputs are registered, so the first byte comes from the incoming word, not word_q.
          if (ID_HEADER) begin
            state_d     = S_HDR;
            byte_data_d = hdr_byte(4'(arb_gnt));
          end else begin
            state_d     = S_DATA;
            byte_data_d = word_d[7:0];
          end
        end
      end
      S_HDR: begin
        if (hs) begin
          state_d     = S_DATA;
          idx_d       = 2'd0;
          byte_data_d = word_q[7:0];
        end
      end
      S_DATA: begin
        if (hs) begin
          if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
            idx_d        = 2'd0;
            state_d      = S_DONE;
            byte_valid_d = 1'b0;
            word_done_d  = 1'b1;
          end else begin
            idx_d       = idx_n;
            byte_data_d = word_q[8*idx_n +: 8];
          end
        end
      end
      S_DONE: begin
        last_d  = grant_id;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      word_q     <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      req_ready  <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      req_ready  <= req_ready_d;
      grant_id   <= grant_d;
      busy       <= busy_d;
      word_done  <= word_done_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed + randomized bench for uart_tx_sched, with a frame-level reference model.
module tb_uart_tx_sched;

  localparam int NR = 4;

  logic          clk;
  logic          rst_n;

  logic          en;
  logic [NR-1:0] req_valid;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [1:0]    grant_id;
  logic          busy;
  logic          word_done;

  logic          en0;
  logic [NR-1:0] req_valid0;
  logic [NR*32-1:0] req_data0;
  logic [NR-1:0] req_ready0;
  logic          byte_valid0;
  logic [7:0]    byte_data0;
  logic          byte_ready0;
  logic [1:0]    grant_id0;
  logic          busy0;
  logic          word_done0;

  int errors = 0;
  int checks = 0;
  int last   = NR - 1;

  uart_tx_sched #(.NUM_REQ(NR), .ID_HEADER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .grant_id(grant_id), .busy(busy), .word_done(word_done)
  );

  uart_tx_sched #(.NUM_REQ(NR), .ID_HEADER(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .byte_valid(byte_valid0), .byte_data(byte_data0),
    .byte_ready(byte_ready0), .grant_id(grant_id0), .busy(busy0), .word_done(word_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first valid requester after the previous winner, wrapping.
  function automatic int next_grant(input logic [NR-1:0] mask, input int prev);
    for (int k = 1; k <= NR; k++)
      if (mask[(prev + k) % NR]) return (prev + k) % NR;
    return -1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),  64'(0));
    check({tag, "_byte_valid"}, 64'(byte_valid), 64'(0));
    check({tag, "_byte_data"},  64'(byte_data),  64'(0));
    check({tag, "_grant_id"},   64'(grant_id),   64'(0));
    check({tag, "_busy"},       64'(busy),       64'(0));
    check({tag, "_word_done"},  64'(word_done),  64'(0));
  endtask

  // Follows one header-mode frame from accept through DONE and the following idle cycle.
  task automatic expect_frame(input int g, input logic [31:0] w, input int stall_k,
                              input int stall_len, input bit drop, input int en_off_k);
    logic [7:0] exp_b [5];
    int n;
    exp_b[0] = {4'hA, 4'(g)};
    for (int i = 0; i < 4; i++) exp_b[i+1] = w[8*i +: 8];
    n = 0;
    while (byte_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("accept_seen", 64'(byte_valid), 64'(1));
    check("req_ready_pulse", 64'(req_ready), 64'(1 << g));
    check("grant_id", 64'(grant_id), 64'(g));
    check("busy_frame", 64'(busy), 64'(1));
    if (drop) req_valid[g] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("byte%0d_valid", k), 64'(byte_valid), 64'(1));
      check($sformatf("byte%0d_data", k), 64'(byte_data), 64'(exp_b[k]));
      if (k == en_off_k) en = 1'b0;
      if (k == stall_k && stall_len > 0) begin
        byte_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          check("stall_valid", 64'(byte_valid), 64'(1));
          check("stall_data", 64'(byte_data), 64'(exp_b[k]));
        end
        byte_ready = 1'b1;
      end
      tick();
      if (k == 0) check("req_ready_once", 64'(req_ready), 64'(0));
    end
    check("word_done", 64'(word_done), 64'(1));
    check("done_busy", 64'(busy), 64'(1));
    check("done_valid", 64'(byte_valid), 64'(0));
    tick();
    check("word_done_once", 64'(word_done), 64'(0));
    check("busy_clear", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] w [NR];
    logic [31:0] wd;
    logic [NR-1:0] mask;
    int g;

    rst_n = 1'b0;
    en = 1'b0; req_valid = '0; req_data = '0; byte_ready = 1'b1;
    en0 = 1'b0; req_valid0 = '0; req_data0 = '0; byte_ready0 = 1'b1;
    #3;
    check_outputs_zero("reset");
    check("reset0_valid", 64'(byte_valid0), 64'(0));
    check("reset0_busy", 64'(busy0), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single word, header mode
    req_data[31:0] = 32'h11223344;
    req_valid = 4'b0001;
    en = 1'b1;
    tick();
    check("accept_latency", 64'(req_ready), 64'(1));
    g = next_grant(4'b0001, last);
    expect_frame(g, 32'h11223344, -1, 0, 1'b1, -1);
    last = g;

    // 2: all requesters valid from fresh reset -> rotation 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last = NR - 1;
    for (int i = 0; i < NR; i++) begin
      w[i] = $urandom;
      req_data[32*i +: 32] = w[i];
    end
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      g = next_grant(4'b1111, last);
      expect_frame(g, w[g], -1, 0, 1'b0, -1);
      last = g;
    end
    req_valid = '0;
    tick();

    // 3: backpressure while 8'h33 is on the bus
    req_data[31:0] = 32'h11223344;
    req_valid = 4'b0001;
    g = next_grant(4'b0001, last);
    expect_frame(g, 32'h11223344, 2, 5, 1'b1, -1);
    last = g;

    // 4: en drops during req1's data; req2 waits for en
    w[1] = $urandom; w[2] = $urandom;
    req_data[32 +: 32] = w[1];
    req_data[64 +: 32] = w[2];
    req_valid = 4'b0110;
    g = next_grant(4'b0110, last);
    expect_frame(g, w[g], -1, 0, 1'b1, 1);
    last = g;
    repeat (3) begin
      tick();
      check("en_low_no_grant", 64'(req_ready), 64'(0));
      check("en_low_idle", 64'(busy), 64'(0));
    end
    en = 1'b1;
    tick();
    g = next_grant(req_valid, last);
    check("en_high_accept", 64'(req_ready), 64'(1 << g));
    expect_frame(g, w[g], -1, 0, 1'b1, -1);
    last = g;

    // 5: reset after two data bytes of req3
    w[3] = $urandom;
    req_data[96 +: 32] = w[3];
    req_valid = 4'b1000;
    tick();
    check("req3_accept", 64'(req_ready), 64'(8));
    tick(); tick(); tick();
    check("req3_byte2", 64'(byte_data), 64'(w[3][23:16]));
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_rst");
    req_data[31:0] = 32'hCAFE0001;
    req_valid = 4'b1001;
    tick(); tick();
    rst_n = 1'b1;
    last = NR - 1;
    g = next_grant(4'b1001, last);
    expect_frame(g, 32'hCAFE0001, -1, 0, 1'b1, -1);
    last = g;
    g = next_grant(req_valid, last);
    expect_frame(g, w[3], -1, 0, 1'b1, -1);
    last = g;

    // Randomized masks, words and stalls
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NR; i++) begin
        w[i] = $urandom;
        req_data[32*i +: 32] = w[i];
      end
      mask = 4'($urandom_range(1, 15));
      req_valid = mask;
      g = next_grant(mask, last);
      expect_frame(g, w[g], $urandom_range(0, 4), $urandom_range(0, 3), 1'b1, -1);
      last = g;
      req_valid = '0;
    end

    // 6: no-header instance
    wd = 32'hDEADBEEF;
    req_data0[64 +: 32] = wd;
    req_valid0 = 4'b0100;
    en0 = 1'b1;
    tick();
    check("nohdr_accept", 64'(req_ready0), 64'(4));
    check("nohdr_grant", 64'(grant_id0), 64'(2));
    req_valid0 = '0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("nohdr_byte%0d", k), 64'(byte_data0), 64'(wd[8*k +: 8]));
      check($sformatf("nohdr_valid%0d", k), 64'(byte_valid0), 64'(1));
      check($sformatf("nohdr_notdone%0d", k), 64'(word_done0), 64'(0));
      tick();
    end
    check("nohdr_word_done", 64'(word_done0), 64'(1));
    check("nohdr_valid_off", 64'(byte_valid0), 64'(0));
    tick();
    check("nohdr_busy_clear", 64'(busy0), 64'(0));
    check("nohdr_done_once", 64'(word_done0), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one byte-level UART transmitter among NUM_REQ word producers. It accepts a 32-bit word from the granted requester and optionally emits a header byte carrying the requester ID. It then sequences the word out as 4 bytes, LSB byte first, so the word-assembling uart_rx on the far side rebuilds it unchanged. It sits between the block-level producers and the shared uart_tx byte interface.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
ID_HEADER, 1, 1 = send the header byte {HDR_MAGIC, id} before the data bytes; 0 = data bytes only.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  grant enable; when low, no new word is accepted
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*32  packed words; requester i uses bits [32*i+31:32*i]
req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
byte_valid  output  1  byte available to the transmitter
byte_data  output  8  byte to transmit
byte_ready  input  1  transmitter accepts the byte (handshake = valid && ready)
grant_id  output  $clog2(NUM_REQ)  ID of the current or last granted requester
busy  output  1  high from the accept cycle until the DONE cycle, inclusive
word_done  output  1  one-cycle pulse after the last data byte handshake

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; byte index 0; rr pointer last_grant = NUM_REQ-1, so requester 0 has highest priority first.
- All outputs are registered. byte_data and byte_valid stay stable until the handshake.
- IDLE: if en && |req_valid:
  - Pick g = first set req_valid bit, searching from last_grant+1 modulo NUM_REQ.
  - Register word_reg <= req_data[g]; req_ready[g] <= 1 for exactly one cycle; grant_id <= g; busy <= 1.
  - Next state is HDR if ID_HEADER, else DATA.
  - Accept latency: req_ready asserts on the clock edge after req_valid is sampled.
- HDR: byte_valid = 1; byte_data = {HDR_MAGIC (4'hA), 4-bit zero-extended grant_id}. On handshake, go to DATA with idx = 0.
- DATA: byte_valid = 1; byte_data = word_reg[8*idx +: 8].
  - On handshake with idx < 3: idx++.
  - On handshake with idx == 3: idx = 0, go to DONE, byte_valid <= 0.
- DONE: word_done = 1 for one cycle; last_grant <= grant_id; busy <= 0; go to IDLE. There is at least one idle cycle between frames.
- byte_ready while byte_valid = 0 is ignored.
- byte_ready low holds the current byte indefinitely; there is no timeout.
- en deasserted mid-frame: the current frame completes normally. en is sampled only in IDLE.
- Requester req_valid drop after its req_ready: no effect, because the word is already latched.
- A requester keeping req_valid high after accept is treated as a new word and re-arbitrated next IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Reset mid-frame: the frame is abandoned. byte_valid drops asynchronously and the latched word is lost. After release, arbitration restarts at requester 0.
- Word throughput bound: (ID_HEADER ? 5 : 4) byte handshakes + 2 cycles per word.

Decomposition:
- uart_pkg additions:
  - typedef enum e_sched_state {S_IDLE, S_HDR, S_DATA, S_DONE};
  - localparam HDR_MAGIC = 4'hA;
  - localparam BYTES_PER_WORD = 4.
- Sub-module rr_arbiter #(N): combinational; inputs req[N] and last_grant; outputs gnt_id and any. The pointer register lives in uart_tx_sched.

Test Plan:
1. ID_HEADER=1, req0 = 32'h11223344, byte_ready tied 1 -> byte_data sequence 8'hA0,44,33,22,11; req_ready[0] one pulse; word_done one pulse; busy low afterwards.
2. All 4 req_valid held high with distinct words -> headers in order A0,A1,A2,A3,A0; each req_ready pulse aligns with its header.
3. Backpressure: byte_ready low 5 cycles while byte 8'h33 is presented -> byte_valid stays 1; byte_data stays 8'h33; no idx advance.
4. en driven low during the DATA of req1 while req2 is valid -> frame 1 completes with word_done; req2 is not granted until en=1, then req2 is accepted one cycle later.
5. rst_n pulsed after 2 data bytes of req3 -> all outputs 0 immediately; after release, req3 valid with req0 valid -> req0 is granted first.
6. ID_HEADER=0, req2 = 32'hDEADBEEF -> bytes EF,BE,AD,DE only; grant_id = 2; word_done after the 4th handshake.
